uart_regfile_loader: RTL
========================

Name: uart_regfile_loader

Overview:
Receive-side counterpart of the register-file dump path. It takes bytes from the UART receiver and waits for a sync byte. It then assembles big-endian 32-bit words (MSB byte first, 4 bytes per register) and writes them into register-file indices 0..NUM_REGS-1 in order. It sits between the UART Rx byte interface and the register file's write port, and is used to preload processor registers over the serial link.

Parameters:
NUM_REGS, 32, number of registers loaded per frame (power of two, ≤32); index width is clog2(NUM_REGS).
TIMEOUT_CYCLES, 100000, maximum clk cycles allowed between consecutive bytes once a frame has started.
SYNC_BYTE, 8'hA5, frame start marker.

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
en  in  1  arm request; sampled only in IDLE
rx_valid  in  1  one-cycle strobe, rx_data valid
rx_data  in  8  received byte
rx_frame_err  in  1  qualifies rx_valid; byte had bad stop bit
we  out  1  register-file write strobe
waddr  out  5  write index
wdata  out  32  write data
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse, full frame written
err  out  1  sticky error flag; cleared on the next accepted arm
reg_count  out  6  number of registers written in the current or last frame

Behaviour:
- Reset values: state IDLE; we=0, waddr=0, wdata=0, done=0, err=0, reg_count=0; internal byte_cnt=0, word=0, timer=0. All outputs registered.
- States: IDLE, WAIT_SYNC, COLLECT, WRITE, DONE, ERROR.
- IDLE: en=1 -> WAIT_SYNC. In the same edge: clear reg_count, byte_cnt and err, and set reg index to 0.
- WAIT_SYNC: accepts a byte only when rx_valid=1 and rx_frame_err=0.
  - rx_data==SYNC_BYTE -> COLLECT and clear timer.
  - Any other byte is discarded; stay in WAIT_SYNC.
  - No timeout applies in this state.
- COLLECT: on rx_valid:
  - rx_frame_err=1 -> ERROR.
  - Otherwise word <= {word[23:0], rx_data}, byte_cnt++, timer cleared.
  - When the 4th byte is accepted (byte_cnt==3), go to WRITE.
  - With no rx_valid, the timer increments; timer==TIMEOUT_CYCLES-1 -> ERROR.
- WRITE (exactly 1 cycle):
  - we=1, waddr=current index, wdata=assembled word. These are visible in the cycle immediately after the edge that sampled the 4th byte.
  - reg_count++ and byte_cnt <= 0.
  - If index==NUM_REGS-1 -> DONE; else index++ and go to COLLECT.
  - An rx_valid arriving in this cycle is accepted as byte 0 of the next word; it is not lost, and the timer is cleared.
- DONE: done=1 for one cycle -> IDLE.
- ERROR: err <= 1 -> IDLE. Registers already written stay written; reg_count shows how many.
- we is deasserted in every state other than WRITE. waddr and wdata hold their last values.
- en while busy=1 is ignored; it is not queued.
- A frame_err byte received in WAIT_SYNC is discarded silently.
- A SYNC_BYTE value inside COLLECT is treated as data, not as a resync.
- Reset mid-frame: immediate return to reset values. A partial frame is abandoned; no write strobe is generated.
- Timer width is clog2(TIMEOUT_CYCLES)+1 bits. It saturates and never wraps.

Test Plan:
1. Full load: arm, send A5, then 128 bytes forming reg i = 32'h1 << i, MSB first. Expect 32 we pulses with waddr 0..31 and matching wdata, then done=1 for one cycle 1 clk after the last write, reg_count=32, err=0, busy=0.
2. Sync hunting: arm, send 00 FF 5A, then A5 12 34 56 78. Expect the junk to be ignored; the first write is waddr=0, wdata=32'h12345678, with we high exactly 1 cycle after the edge that sampled 8'h78.
3. Timeout: arm, send A5 DE AD, then idle TIMEOUT_CYCLES cycles (bench sets TIMEOUT_CYCLES=50). Expect err=1, busy=0, no we, reg_count=0. Re-arm clears err.
4. Frame error: arm, send A5, a full word, then a byte with rx_frame_err=1. Expect a single write (waddr=0), then err=1, reg_count=1, no done.
5. Back-to-back: rx_valid strobe in the WRITE cycle carrying byte 0 of reg 1. Expect reg 1 assembled correctly.
6. en pulses while busy, and rst asserted mid-word. Expect en to have no effect; after rst all outputs are 0 and there is no spurious we.

Source files
------------

// File: rtl/uart_regfile_loader_if.sv
// Purpose : Groups the two byte/word buses around the UART register-file loader.
//           The receive side carries bytes from the UART Rx into the loader.
//           The write side carries word writes from the loader into the register file.
// Signals : rx_valid     - one-cycle strobe; rx_data holds a byte
//           rx_data      - received byte
//           rx_frame_err - qualifies rx_valid; the byte had a bad stop bit
//           we           - register-file write strobe
//           waddr        - register-file write index
//           wdata        - register-file write data
// Modports: slave  - the loader: consumes rx_*, drives we/waddr/wdata
//           master - the environment: drives rx_*, observes the write port
interface uart_regfile_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_frame_err;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  modport slave (
    input  rx_valid, rx_data, rx_frame_err,
    output we, waddr, wdata
  );

  modport master (
    output rx_valid, rx_data, rx_frame_err,
    input  we, waddr, wdata
  );
endinterface

// File: rtl/uart_regfile_loader.sv
// Purpose : Hunts for a sync byte on the UART Rx byte stream. It then assembles
//           big-endian 32-bit words (MSB byte first) and writes them to register
//           indices 0..NUM_REGS-1 in order. A frame error or an inter-byte timeout
//           aborts the frame and raises a sticky err flag.
// Ports   : clk, rst   - clock; asynchronous active-high reset
//           en         - arm request, honoured only while idle
//           bus        - Rx byte inputs and register-file write outputs (slave modport)
//           busy       - high whenever the loader is not idle
//           done       - one-cycle pulse after the last register of a frame is written
//           err        - sticky error; cleared by the next accepted arm
//           reg_count  - registers written in the current or last frame
module uart_regfile_loader #(
  parameter int          NUM_REGS       = 32,
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  uart_regfile_loader_if.slave  bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [5:0]            reg_count
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_SYNC, S_COLLECT, S_WRITE, S_DONE, S_ERROR
  } state_t;

  state_t            r_state,     w_state;
  logic [1:0]        r_byte_cnt,  w_byte_cnt;
  logic [31:0]       r_word,      w_word;
  logic [TMR_W-1:0]  r_timer,     w_timer;
  logic [IDX_W-1:0]  r_idx,       w_idx;
  logic              r_we,        w_we;
  logic [4:0]        r_waddr,     w_waddr;
  logic [31:0]       r_wdata,     w_wdata;
  logic              r_done,      w_done;
  logic              r_err,       w_err;
  logic [5:0]        r_reg_count, w_reg_count;

  logic              w_accept;
  logic [31:0]       w_shift;

  assign w_accept = bus.rx_valid && !bus.rx_frame_err;
  assign w_shift  = {r_word[23:0], bus.rx_data};

  always_comb begin
    w_state     = r_state;
    w_byte_cnt  = r_byte_cnt;
    w_word      = r_word;
    w_timer     = r_timer;
    w_idx       = r_idx;
    w_we        = 1'b0;
    w_waddr     = r_waddr;
    w_wdata     = r_wdata;
    w_done      = 1'b0;
    w_err       = r_err;
    w_reg_count = r_reg_count;

    case (r_state)
      S_IDLE: begin
        if (en) begin
          w_state     = S_WAIT_SYNC;
          w_reg_count = '0;
          w_byte_cnt  = '0;
          w_err       = 1'b0;
          w_idx       = '0;
        end
      end

      // Frame-errored and non-sync bytes are dropped; no timeout while hunting.
      S_WAIT_SYNC: begin
        if (w_accept && (bus.rx_data == SYNC_BYTE)) begin
          w_state    = S_COLLECT;
          w_timer    = '0;
          w_byte_cnt = '0;
        end
      end

      S_COLLECT: begin
        if (bus.rx_valid) begin
          if (bus.rx_frame_err) begin
            w_state = S_ERROR;
            w_err   = 1'b1;
          end else begin
            w_word     = w_shift;
            w_byte_cnt = r_byte_cnt + 2'd1;
            w_timer    = '0;
            // Register the write port here so we/waddr/wdata appear in the WRITE cycle.
            if (r_byte_cnt == 2'd3) begin
              w_state = S_WRITE;
              w_we    = 1'b1;
              w_waddr = 5'(r_idx);
              w_wdata = w_shift;
            end
          end
        end else if (r_timer == TMR_LAST) begin
          w_state = S_ERROR;
          w_err   = 1'b1;
        end else if (r_timer != TMR_MAX) begin
          w_timer = r_timer + TMR_W'(1);
        end
      end

      S_WRITE: begin
        w_reg_count = r_reg_count + 6'd1;
        w_byte_cnt  = '0;
        if (r_idx == LAST_IDX) begin
          w_state = S_DONE;
          w_done  = 1'b1;
        end else begin
          w_state = S_COLLECT;
          w_idx   = r_idx + IDX_W'(1);
          // A byte landing in the write cycle is byte 0 of the next word.
          if (bus.rx_valid) begin
            if (bus.rx_frame_err) begin
              w_state = S_ERROR;
              w_err   = 1'b1;
            end else begin
              w_word     = w_shift;
              w_byte_cnt = 2'd1;
              w_timer    = '0;
            end
          end
        end
      end

      S_DONE:  w_state = S_IDLE;
      S_ERROR: w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_byte_cnt  <= '0;
      r_word      <= '0;
      r_timer     <= '0;
      r_idx       <= '0;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_reg_count <= '0;
    end else begin
      r_state     <= w_state;
      r_byte_cnt  <= w_byte_cnt;
      r_word      <= w_word;
      r_timer     <= w_timer;
      r_idx       <= w_idx;
      r_we        <= w_we;
      r_waddr     <= w_waddr;
      r_wdata     <= w_wdata;
      r_done      <= w_done;
      r_err       <= w_err;
      r_reg_count <= w_reg_count;
    end
  end

  assign bus.we    = r_we;
  assign bus.waddr = r_waddr;
  assign bus.wdata = r_wdata;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign err       = r_err;
  assign reg_count = r_reg_count;

endmodule
